// File: rtl/pll_reconfig_seq.sv
// ---------------------------------------------------------------------------
// pll_reconfig_seq
//
// Reprograms a fractional PLL through its reconfiguration management port
// whenever the requested profile differs from the profile last applied.
// A sequence performs eight register writes, then waits for the PLL to
// drop lock and regain it. Every lock wait is bounded by LOCK_TIMEOUT. If
// the PLL does not re-lock in time, the PLL is reset and a sticky error is
// raised.
//
// Ports
//   clk_74a          in   sole clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   profile_sel      in   requested profile (asynchronous, synchronized here)
//   pll_locked       in   PLL lock indication (asynchronous, synchronized here)
//   mgmt_address     out  reconfig register address
//   mgmt_write       out  write strobe (registered)
//   mgmt_writedata   out  write data
//   mgmt_waitrequest in   reconfig not ready / write not accepted
//   pll_rst          out  PLL reset request, 16-cycle pulse after a lock timeout
//   busy             out  reconfiguration sequence in progress
//   done             out  one-cycle pulse when a sequence completes
//   error            out  sticky lock-timeout flag, cleared by the next done
// ---------------------------------------------------------------------------
module pll_reconfig_seq #(
    parameter logic [31:0] M_WORD       = 32'h0000_0404,
    parameter logic [31:0] K0           = 32'd425936216,
    parameter logic [31:0] K1           = 32'd0,
    parameter logic [31:0] C0_P0        = 32'd0,
    parameter logic [31:0] C1_P0        = 32'd0,
    parameter logic [31:0] C2_P0        = 32'd0,
    parameter logic [31:0] C3_P0        = 32'd0,
    parameter logic [31:0] C0_P1        = 32'd0,
    parameter logic [31:0] C1_P1        = 32'd0,
    parameter logic [31:0] C2_P1        = 32'd0,
    parameter logic [31:0] C3_P1        = 32'd0,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd7_425_000
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic        profile_sel,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    output logic        pll_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        WR,
        WR_ACK,
        START,
        WAIT_UNLK,
        WAIT_LK
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic        tgt;
    logic        cur_prof;
    logic        sel_meta;
    logic        sel_s;
    logic        lock_meta;
    logic        lock_s;
    logic [23:0] cnt;
    logic [3:0]  rst_left;
    logic        timed_out;

    // The counter never passes LOCK_TIMEOUT, so ">=" and "==" are equivalent.
    // ">=" also keeps LOCK_TIMEOUT=0 well defined.
    assign timed_out = (cnt >= LOCK_TIMEOUT);

    // Register address of each write in the reprogramming sequence.
    function automatic logic [5:0] entry_addr(input logic [2:0] i);
        logic [5:0] a;
        case (i)
            3'd0:                   a = 6'd0;
            3'd1:                   a = 6'd4;
            3'd2:                   a = 6'd7;
            3'd3, 3'd4, 3'd5, 3'd6: a = 6'd5;
            default:                a = 6'd2;
        endcase
        return a;
    endfunction

    // Write data of each sequence entry for profile p.
    function automatic logic [31:0] entry_data(input logic [2:0] i, input logic p);
        logic [31:0] d;
        case (i)
            3'd0:    d = 32'd0;
            3'd1:    d = M_WORD;
            3'd2:    d = p ? K1    : K0;
            3'd3:    d = p ? C0_P1 : C0_P0;
            3'd4:    d = p ? C1_P1 : C1_P0;
            3'd5:    d = p ? C2_P1 : C2_P0;
            3'd6:    d = p ? C3_P1 : C3_P0;
            default: d = 32'd1;
        endcase
        return d;
    endfunction

    // Two-flop synchronizers for the asynchronous profile and lock inputs.
    // Nothing downstream looks at the raw pins.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sel_meta  <= 1'b0;
            sel_s     <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sel_meta  <= profile_sel;
            sel_s     <= sel_meta;
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer. All outputs are registered here, so mgmt_write has no
    // combinational path from mgmt_waitrequest. A write completes on an edge
    // where mgmt_write is high and mgmt_waitrequest is low. The address and
    // data are loaded only when a write is launched, which keeps them stable
    // for the whole write, including while mgmt_waitrequest stalls it.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= 3'd0;
            tgt            <= 1'b0;
            cur_prof       <= 1'b0;
            cnt            <= 24'd0;
            rst_left       <= 4'd0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            pll_rst        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            done <= 1'b0;

            // pll_rst runs off its own down-counter: 15 decrements plus the
            // cycle it was raised in give a 16-cycle pulse.
            if (pll_rst) begin
                if (rst_left == 4'd0) begin
                    pll_rst <= 1'b0;
                end else begin
                    rst_left <= rst_left - 4'd1;
                end
            end

            case (state)
                IDLE: begin
                    // The target is captured once here. Later profile_sel
                    // changes only take effect after this sequence finishes.
                    if ((sel_s != cur_prof) && lock_s) begin
                        tgt   <= sel_s;
                        busy  <= 1'b1;
                        state <= WAIT_RDY;
                    end
                end

                WAIT_RDY: begin
                    if (!mgmt_waitrequest) begin
                        idx            <= 3'd0;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= entry_addr(3'd0);
                        mgmt_writedata <= entry_data(3'd0, tgt);
                        state          <= WR;
                    end
                end

                WR: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        state      <= (idx == 3'd7) ? START : WR_ACK;
                    end
                end

                WR_ACK: begin
                    idx            <= idx + 3'd1;
                    mgmt_write     <= 1'b1;
                    mgmt_address   <= entry_addr(idx + 3'd1);
                    mgmt_writedata <= entry_data(idx + 3'd1, tgt);
                    state          <= WR;
                end

                START: begin
                    cnt   <= 24'd0;
                    state <= WAIT_UNLK;
                end

                WAIT_UNLK: begin
                    // Missing the unlock is not fatal. A fast PLL can re-lock
                    // before the synchronizer sees it drop.
                    if (!lock_s || timed_out) begin
                        cnt   <= 24'd0;
                        state <= WAIT_LK;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end

                WAIT_LK: begin
                    if (lock_s) begin
                        cur_prof <= tgt;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        error    <= 1'b0;
                        state    <= IDLE;
                    end else if (timed_out) begin
                        // Kick the PLL and keep waiting. The window restarts.
                        error    <= 1'b1;
                        pll_rst  <= 1'b1;
                        rst_left <= 4'd15;
                        cnt      <= 24'd0;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_reconfig_seq
//
// Scoreboard bench for pll_reconfig_seq. Each profile request pushes the
// expected write sequence and the done pulse into a queue, built from the
// reference table below. A monitor process pops entries as the DUT completes
// writes and pulses done. Separate processes play the reconfig block
// (waitrequest) and the PLL (lock drop and re-lock).
// ---------------------------------------------------------------------------
module tb_pll_reconfig_seq;

    localparam logic [31:0] TB_M    = 32'h0000_0404;
    localparam logic [31:0] TB_K0   = 32'd425936216;
    localparam logic [31:0] TB_K1   = 32'h0ABC_DEF0;
    localparam logic [31:0] TB_C0P0 = 32'h0000_0505;
    localparam logic [31:0] TB_C1P0 = 32'h0004_0606;
    localparam logic [31:0] TB_C2P0 = 32'h0008_0707;
    localparam logic [31:0] TB_C3P0 = 32'h000C_0808;
    localparam logic [31:0] TB_C0P1 = 32'h0000_1313;
    localparam logic [31:0] TB_C1P1 = 32'h0004_1414;
    localparam logic [31:0] TB_C2P1 = 32'h0008_1515;
    localparam logic [31:0] TB_C3P1 = 32'h000C_1616;
    localparam logic [23:0] TB_LT   = 24'd100;

    logic        clk_74a          = 1'b0;
    logic        reset_n          = 1'b1;
    logic        profile_sel      = 1'b0;
    logic        pll_locked       = 1'b1;
    logic        mgmt_waitrequest = 1'b0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        pll_rst;
    logic        busy;
    logic        done;
    logic        error;

    pll_reconfig_seq #(
        .M_WORD(TB_M), .K0(TB_K0), .K1(TB_K1),
        .C0_P0(TB_C0P0), .C1_P0(TB_C1P0), .C2_P0(TB_C2P0), .C3_P0(TB_C3P0),
        .C0_P1(TB_C0P1), .C1_P1(TB_C1P1), .C2_P1(TB_C2P1), .C3_P1(TB_C3P1),
        .LOCK_TIMEOUT(TB_LT)
    ) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .profile_sel(profile_sel),
        .pll_locked(pll_locked),
        .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_rst(pll_rst),
        .busy(busy),
        .done(done),
        .error(error)
    );

    typedef struct {
        bit          is_done;
        bit          first;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic        model_prof  = 1'b0;
    int          wr_mode     = 0;
    int          stall_cnt   = 0;
    bit          auto_lock   = 1'b1;

    logic [5:0]  ref_addr [8];
    logic [31:0] ref_k    [2];
    logic [31:0] ref_c    [2][4];

    int          wr_cnt         = 0;
    int          last_start_cyc = 0;
    int          last_done_cyc  = 0;
    int          last_k_width   = 0;
    int          last_rst_width = 0;
    int          rst_pulses     = 0;

    // 74.25 MHz-ish clock; only cycle counts matter here.
    initial begin
        forever #5 clk_74a = ~clk_74a;
    end

    // Free-running cycle count for latency windows.
    initial begin
        forever begin
            @(posedge clk_74a);
            cyc++;
        end
    end

    // Global safety net in case some bounded wait is itself broken.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string why);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: %s", name, why);
    endtask

    // Reference sequence for one profile change: eight writes, then done.
    task automatic pushSequence(input logic prof);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.is_done = 1'b0;
            e.first   = (i == 0);
            e.addr    = ref_addr[i];
            case (ref_addr[i])
                6'd0:    e.data = 32'd0;
                6'd4:    e.data = TB_M;
                6'd7:    e.data = ref_k[prof];
                6'd5:    e.data = ref_c[prof][i-3];
                default: e.data = 32'd1;
            endcase
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.first   = 1'b0;
        e.addr    = 6'd0;
        e.data    = 32'd0;
        exp_q.push_back(e);
    endtask

    // Drive a new profile request. A change from the last applied profile
    // means one full sequence is owed.
    task automatic applyStimulus(input logic sel);
        @(posedge clk_74a);
        #1;
        profile_sel = sel;
        if (sel != model_prof) begin
            pushSequence(sel);
            model_prof = sel;
        end
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_74a);
            n++;
        end while (!done && n < budget);
        if (!done) failNow(name, "done pulse not seen within cycle budget");
    endtask

    // Reconfig block model: mode 0 always ready, mode 1 random stalls,
    // mode 2 stalls the K write (address 7) for exactly five cycles.
    initial begin
        forever begin
            @(posedge clk_74a);
            #1;
            case (wr_mode)
                1: mgmt_waitrequest = ($urandom_range(0, 3) == 0);
                2: begin
                    if (mgmt_write && mgmt_address == 6'd7 && stall_cnt < 5) begin
                        mgmt_waitrequest = 1'b1;
                        stall_cnt++;
                    end else begin
                        mgmt_waitrequest = 1'b0;
                    end
                end
                default: mgmt_waitrequest = 1'b0;
            endcase
        end
    end

    // PLL model: after the start write is accepted, drop lock after a short
    // random delay, then re-lock after a random time.
    initial begin
        forever begin
            @(negedge clk_74a);
            if (auto_lock && reset_n && mgmt_write && !mgmt_waitrequest &&
                mgmt_address == 6'd2) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_74a);
                #1 pll_locked = 1'b0;
                repeat ($urandom_range(3, 10)) @(posedge clk_74a);
                #1 pll_locked = 1'b1;
            end
        end
    end

    // Monitor: compares every write cycle and every done pulse against the
    // scoreboard. It also checks the idle gap between writes, that a stalled
    // write is never dropped, that done lasts one cycle, and the pll_rst width.
    initial begin
        bit   in_write;
        bit   stalled_prev;
        bit   prev_done;
        int   width;
        int   gap;
        int   rst_w;
        exp_t e;
        in_write = 0; stalled_prev = 0; prev_done = 0;
        width = 0; gap = 0; rst_w = 0;
        forever begin
            @(negedge clk_74a);
            if (!reset_n) begin
                in_write = 0; stalled_prev = 0; prev_done = 0;
                width = 0; gap = 0; rst_w = 0;
            end else begin
                if (pll_rst) begin
                    rst_w++;
                end else if (rst_w != 0) begin
                    last_rst_width = rst_w;
                    rst_pulses++;
                    rst_w = 0;
                end

                if (prev_done) checkOutput("done_one_cycle", done, 1'b0);
                prev_done = done;
                if (done) begin
                    last_done_cyc = cyc;
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        failNow("done_order", "done pulse while writes still expected or none owed");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("done_error_clear", error, 1'b0);
                        checkOutput("done_busy_low", busy, 1'b0);
                    end
                end

                if (mgmt_write) begin
                    if (!in_write) begin
                        in_write = 1;
                        width    = 0;
                        if (exp_q.size() != 0 && !exp_q[0].is_done && !exp_q[0].first)
                            checkOutput("write_gap", gap, 1);
                    end
                    width++;
                    if (exp_q.size() != 0 && !exp_q[0].is_done) begin
                        checkOutput("write_addr", mgmt_address, exp_q[0].addr);
                        checkOutput("write_data", mgmt_writedata, exp_q[0].data);
                    end
                    if (mgmt_waitrequest) begin
                        stalled_prev = 1;
                    end else begin
                        stalled_prev = 0;
                        if (exp_q.size() == 0 || exp_q[0].is_done) begin
                            failNow("unexpected_write", $sformatf("addr 0x%0h data 0x%0h",
                                    mgmt_address, mgmt_writedata));
                        end else begin
                            e = exp_q.pop_front();
                            if (e.addr == 6'd2) last_start_cyc = cyc;
                            if (e.addr == 6'd7) last_k_width = width;
                        end
                        wr_cnt++;
                        in_write = 0;
                        gap      = 0;
                    end
                end else begin
                    if (stalled_prev) checkOutput("write_held", mgmt_write, 1'b1);
                    stalled_prev = 0;
                    in_write     = 0;
                    gap++;
                end
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin : stim
        int   base;
        int   n;
        int   t0;
        int   diff;
        logic sel;

        ref_addr = '{6'd0, 6'd4, 6'd7, 6'd5, 6'd5, 6'd5, 6'd5, 6'd2};
        ref_k[0] = TB_K0;
        ref_k[1] = TB_K1;
        ref_c[0] = '{TB_C0P0, TB_C1P0, TB_C2P0, TB_C3P0};
        ref_c[1] = '{TB_C0P1, TB_C1P1, TB_C2P1, TB_C3P1};

        // Reset with profile 0 and lock high: nothing happens.
        #2 reset_n = 1'b0;
        #1 checkOutput("reset_outputs",
                       {mgmt_write, mgmt_address, mgmt_writedata, pll_rst, busy, done, error}, 0);
        repeat (3) @(posedge clk_74a);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_74a);
            checkOutput("idle_busy", busy, 1'b0);
            checkOutput("idle_write", mgmt_write, 1'b0);
        end

        // A request without lock is held off until lock returns.
        @(posedge clk_74a);
        #1 pll_locked = 1'b0;
        repeat (5) @(posedge clk_74a);
        applyStimulus(1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_74a);
            checkOutput("held_no_lock_busy", busy, 1'b0);
            checkOutput("held_no_lock_write", mgmt_write, 1'b0);
        end
        @(posedge clk_74a);
        #1 pll_locked = 1'b1;
        waitDone("seq_p1_done", 500);

        // The K write is stalled for five cycles, so the strobe stays high six.
        @(posedge clk_74a);
        #1;
        stall_cnt = 0;
        wr_mode   = 2;
        applyStimulus(1'b0);
        waitDone("seq_stall_done", 500);
        checkOutput("k_write_width", last_k_width, 6);
        wr_mode = 0;

        // The PLL never drops lock: the unlock wait times out and the
        // sequence still completes.
        auto_lock = 1'b0;
        applyStimulus(1'b1);
        waitDone("seq_unlk_timeout_done", 1000);
        diff = last_done_cyc - last_start_cyc;
        checkOutput("unlk_timeout_window", (diff >= 100 && diff <= 110), 1'b1);

        // The PLL drops lock and stays down: error, pll_rst pulse, then recovery.
        applyStimulus(1'b0);
        n = 0;
        do begin
            @(negedge clk_74a);
            n++;
        end while (!(mgmt_write && !mgmt_waitrequest && mgmt_address == 6'd2) && n < 500);
        if (n >= 500) failNow("start_write_wait", "start write not seen within cycle budget");
        repeat (2) @(posedge clk_74a);
        #1 pll_locked = 1'b0;
        t0 = cyc;
        base = rst_pulses;
        n = 0;
        do begin
            @(negedge clk_74a);
            n++;
        end while (!error && n < 500);
        diff = cyc - t0;
        checkOutput("lock_timeout_window", (diff >= 100 && diff <= 110), 1'b1);
        n = 0;
        do begin
            @(negedge clk_74a);
            n++;
        end while (rst_pulses == base && n < 100);
        checkOutput("pll_rst_width", last_rst_width, 16);
        checkOutput("error_set", error, 1'b1);
        repeat (10) @(negedge clk_74a);
        checkOutput("error_sticky", error, 1'b1);
        checkOutput("busy_in_lock_wait", busy, 1'b1);
        @(posedge clk_74a);
        #1 pll_locked = 1'b1;
        waitDone("seq_relock_done", 500);
        auto_lock = 1'b1;

        // profile_sel flips back during the idx 4 write: the first sequence
        // finishes with K1, and a K0 sequence starts right after done.
        base = wr_cnt;
        applyStimulus(1'b1);
        n = 0;
        do begin
            @(negedge clk_74a);
            n++;
        end while (!(wr_cnt >= base + 4 && mgmt_write) && n < 500);
        if (n >= 500) failNow("idx4_wait", "idx 4 write not seen within cycle budget");
        profile_sel = 1'b0;
        pushSequence(1'b0);
        model_prof = 1'b0;
        waitDone("seq_toggle_first_done", 500);
        @(negedge clk_74a);
        checkOutput("restart_next_cycle", busy, 1'b1);
        waitDone("seq_toggle_second_done", 500);

        // Reset during WR_ACK clears everything, and the sequence reruns
        // from the top.
        applyStimulus(1'b1);
        n = 0;
        do begin
            @(negedge clk_74a);
            n++;
        end while (!(mgmt_write && !mgmt_waitrequest && mgmt_address == 6'd7) && n < 500);
        if (n >= 500) failNow("k_write_wait", "K write not seen within cycle budget");
        @(posedge clk_74a);
        #1 reset_n = 1'b0;
        #1 checkOutput("reset_in_wr_ack",
                       {mgmt_write, mgmt_address, mgmt_writedata, pll_rst, busy, done, error}, 0);
        exp_q.delete();
        model_prof = 1'b0;
        repeat (3) @(posedge clk_74a);
        #1 reset_n = 1'b1;
        applyStimulus(1'b1);
        waitDone("seq_after_reset_done", 500);

        // Randomized requests with random waitrequest stalls and lock timing.
        wr_mode = 1;
        for (int i = 0; i < 8; i++) begin
            sel = 1'($urandom_range(0, 1));
            if (sel != model_prof) begin
                applyStimulus(sel);
                waitDone("random_seq_done", 2000);
            end else begin
                applyStimulus(sel);
            end
            repeat ($urandom_range(5, 20)) @(posedge clk_74a);
        end
        wr_mode = 0;
        repeat (20) @(posedge clk_74a);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 Parameter M_WORD, 32'h0000_0404: M-counter word written to address 4.
REQ-002 Parameter K0, 32'd425936216: fractional K for profile 0.
REQ-003 Parameter K1, 32'd0: fractional K for profile 1.
REQ-004 Parameters C0_P0..C3_P0 and C0_P1..C3_P1, default 32'd0: C-counter words, each carrying its counter index in bits [22:18].
REQ-005 Parameter LOCK_TIMEOUT, 24'd7_425_000 (100 ms at 74.25 MHz): cycle limit for each lock wait.
REQ-006 The ports SHALL be:
- clk_74a  in  1  sole clock, rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- profile_sel  in  1  requested profile, asynchronous to clk_74a.
- pll_locked  in  1  PLL locked, asynchronous.
- mgmt_address  out  6  reconfig register address.
- mgmt_write  out  1  write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_waitrequest  in  1  reconfig not ready / write not accepted.
- pll_rst  out  1  PLL reset request.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on success.
- error  out  1  sticky timeout flag.

Function
REQ-007 profile_sel and pll_locked SHALL each pass through a 2-flop synchronizer; all logic uses only the synchronized copies (sel_s, lock_s).
REQ-008 cur_prof (1 bit) SHALL hold the last applied profile; a sequence is requested whenever sel_s != cur_prof.
REQ-009 FSM states SHALL be: IDLE, WAIT_RDY, WR, WR_ACK, START, WAIT_UNLK, WAIT_LK.
REQ-010 IDLE: request and lock_s=1 -> WAIT_RDY; latch tgt=sel_s; busy=1.
REQ-011 WAIT_RDY: mgmt_waitrequest=0 -> WR with idx=0.
REQ-012 WR SHALL drive mgmt_write=1 with the entry selected by idx:
- idx 0: addr 0, data 0 (waitrequest mode).
- idx 1: addr 4, data M_WORD.
- idx 2: addr 7, data K(tgt).
- idx 3-6: addr 5, data C0..C3 of profile tgt.
- idx 7: addr 2, data 1 (start).
REQ-013 A write SHALL complete on the first rising edge with mgmt_write=1 and mgmt_waitrequest=0. mgmt_address and mgmt_writedata SHALL stay stable while mgmt_waitrequest=1.
REQ-014 After a completed write with idx<7, the FSM SHALL deassert mgmt_write for exactly one cycle (WR_ACK), increment idx, then return to WR.
REQ-015 After the start write (idx=7) completes -> START. START SHALL last one cycle, then go to WAIT_UNLK with the timeout counter cleared.
REQ-016 WAIT_UNLK: lock_s=0 -> WAIT_LK with counter cleared. If counter reaches LOCK_TIMEOUT -> WAIT_LK (PLL may re-lock too fast to observe).
REQ-017 WAIT_LK: lock_s=1 -> IDLE; cur_prof<=tgt; done=1 for one cycle; busy=0.
REQ-018 WAIT_LK: counter reaches LOCK_TIMEOUT -> error<=1, pll_rst=1 for 16 cycles, counter cleared, remain in WAIT_LK.
REQ-019 The timeout counter SHALL be 24 bits, saturate at LOCK_TIMEOUT and never wrap.
REQ-020 A profile_sel change while busy=1 SHALL NOT alter tgt. The mismatch sel_s != cur_prof persists, so a new sequence starts on the cycle after done.
REQ-021 IDLE with lock_s=0 SHALL not start a sequence; the request is held until lock_s=1.
REQ-022 error SHALL clear only on reset or on the next done pulse.
REQ-023 mgmt_write SHALL be registered (no combinational path from mgmt_waitrequest).

Reset
REQ-024 reset_n=0 SHALL immediately force: state=IDLE, idx=0, cur_prof=0, counter=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, pll_rst=0, busy=0, done=0, error=0, synchronizers=0.
REQ-025 Reset mid-write SHALL drop mgmt_write asynchronously. On release, a pending profile 1 request re-runs the full sequence from idx 0.

Verification
REQ-026 Bench SHALL cover: reset release with profile_sel=0 and locked=1 -> no mgmt_write, busy=0 indefinitely.
REQ-027 Bench SHALL cover: profile_sel 0->1, waitrequest=0 -> exactly 8 writes (addr 0,4,7,5,5,5,5,2; data at addr 7 = K1), each one cycle wide with 1 idle cycle between; locked drop then rise -> one done pulse, busy=0.
REQ-028 Bench SHALL cover: waitrequest held 1 for 5 cycles on the idx 2 write -> mgmt_write high for 6 cycles, address/data constant, no write skipped.
REQ-029 Bench SHALL cover: locked never returns, LOCK_TIMEOUT=100 -> WAIT_UNLK timeout after 100 cycles, then error=1 and pll_rst high for 16 cycles; locked then rises -> done pulse, error=0.
REQ-030 Bench SHALL cover: profile_sel toggles 1->0 during the idx 4 write -> the first sequence completes with K1, then a second sequence writes K0 starting the cycle after done.
REQ-031 Bench SHALL cover: reset_n pulsed low during WR_ACK -> all outputs 0 within the same cycle, cur_prof=0; with profile_sel=1, the sequence restarts at addr 0 after release.
